serial_link_credit_ctrl: RTL and testbench
==========================================

Name: serial_link_credit_ctrl

Overview:
- Credit-based flow-control stage between the link-layer packetizer (upstream) and the PHY TX path (downstream).
- Gates outgoing packets on the peer's free receive-FIFO slots, counted as credits.
- Counts locally consumed receive packets and returns them to the peer, piggybacked on data packets or in credit-only packets.
- Uses serial_link_pkg::NumCredits and credit_t widths.

Parameters:
- NumCredits, serial_link_pkg::NumCredits (8), depth of the peer receive FIFO and the initial credit count.
- ForceSendThresh, NumCredits/2 (4), pending-return count that triggers a credit-only packet when no data launches.
- DataWidth, 64, payload width in bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_in_valid_i  in  1  upstream packet valid
- data_in_ready_o  out  1  upstream packet accepted (combinational)
- data_in_i  in  DataWidth  upstream payload
- data_out_valid_o  out  1  packet valid to PHY TX
- data_out_ready_i  in  1  PHY TX ready
- data_out_o  out  DataWidth  registered payload; all zeros for credit-only packets
- data_out_credits_o  out  $clog2(NumCredits)+1  credits returned to the peer by this packet
- data_out_credit_only_o  out  1  packet carries no payload
- credits_rcvd_valid_i  in  1  peer returned credits this cycle
- credits_rcvd_i  in  $clog2(NumCredits)+1  number of returned credits
- rcvd_pkt_consumed_i  in  1  local consumer popped one received packet
- credits_avail_o  out  $clog2(NumCredits)+1  current available credits
- credits_pending_o  out  $clog2(NumCredits)+1  credits not yet returned
- credit_err_o  out  1  sticky overflow error

Behaviour:
- Reset (asynchronous, active low) values:
  - state Idle; data_out_valid_o=0; data_out_o=0; data_out_credits_o=0; data_out_credit_only_o=0.
  - avail=NumCredits; pending=0; credit_err_o=0.
- FSM states: Idle, Busy. The output register is loaded only on a launch.
- A launch is allowed when state=Idle, or when state=Busy and data_out_ready_i=1. Busy with a handshake can launch again in the same cycle, so the block sustains one packet per cycle.
- Launch priority:
  1. Data launch when data_in_valid_i=1 and avail>=2. The last credit is reserved so a credit-only packet can always be sent, which avoids deadlock.
  2. Otherwise, credit-only launch when pending>=ForceSendThresh and avail>=1.
- data_in_ready_o=1 only in the cycle of a data launch.
- On launch:
  - Output register takes data_in_i (or 0 for credit-only), credits=pending, and credit_only flag.
  - Next state is Busy.
- Busy with a handshake and no new launch returns to Idle.
- Output stability: while data_out_valid_o=1 and data_out_ready_i=0, all data_out_* outputs are held stable.
- Credit arithmetic per cycle:
  - avail_next = avail - launch + (credits_rcvd_valid_i ? credits_rcvd_i : 0).
  - Credits are decremented at launch, not at handshake.
  - avail_next > NumCredits: avail saturates at NumCredits and credit_err_o is set.
  - pending_next = (launch ? 0 : pending) + rcvd_pkt_consumed_i. A consume in the launch cycle yields pending=1 after launch.
  - pending reaching above NumCredits saturates at NumCredits and sets credit_err_o.
- credit_err_o clears only on reset.
- credits_avail_o and credits_pending_o are the registered counter values.
- A reset mid-transfer drops any held packet immediately, with no handshake required.

Test Plan:
- Reset, then drive 7 back-to-back data packets with data_out_ready_i=1 -> all 7 accepted in 7 consecutive cycles; avail 8→1. An 8th data packet stalls with data_in_ready_o=0.
- From avail=1, pulse rcvd_pkt_consumed_i 4 times -> credit-only packet with data_out_credits_o=4, data_out_o=0, credit_only=1; avail=0, pending=0.
- From avail=0, send credits_rcvd_valid_i with credits_rcvd_i=3 -> avail=3; the stalled data packet launches next cycle and avail becomes 2.
- Launch a data packet with pending=2, hold data_out_ready_i=0 for 5 cycles while consuming 3 packets -> data_out_credits_o stays 2 and payload is stable; pending=3.
- Consume in the same cycle as a data launch with pending=5 -> packet carries 5; pending=1 afterwards.
- From avail=8, send credits_rcvd_i=2 -> avail stays 8; credit_err_o=1 and remains set until rst_ni is asserted.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link blocks.
//   NumCredits   : depth of the peer receive FIFO, which is also the initial credit count.
//   CreditWidth  : width of any credit count; it can hold 0..NumCredits inclusive.
//   credit_t     : credit count type.
//   credit_state_e : launch FSM state of serial_link_credit_ctrl, exported for debug.
package serial_link_pkg;

  localparam int NumCredits  = 8;
  localparam int CreditWidth = $clog2(NumCredits) + 1;

  typedef logic [CreditWidth-1:0] credit_t;

  typedef enum logic {
    Idle = 1'b0,
    Busy = 1'b1
  } credit_state_e;

endpackage

// File: rtl/serial_link_credit_ctrl_if.sv
// Bundle of every non-clock signal of serial_link_credit_ctrl.
//   slave  : seen from the credit controller.
//   master : seen from the environment (packetizer, PHY TX, peer credit return, consumer).
//
// Handshake rules for both packet channels (data_in_*, data_out_*): a transfer
// happens on a rising clock edge where valid and ready are both 1. The producer
// holds valid and all payload fields stable until that transfer. data_in_ready_o
// is combinational and may depend on data_in_valid_i. The credit return
// (credits_rcvd_*) and the consume pulse (rcvd_pkt_consumed_i) have no ready.
// They are taken in every cycle where they are asserted.
interface serial_link_credit_ctrl_if #(
  parameter int DataWidth   = 64,
  parameter int CreditWidth = serial_link_pkg::CreditWidth
);

  logic                   data_in_valid_i;
  logic                   data_in_ready_o;
  logic [DataWidth-1:0]   data_in_i;
  logic                   data_out_valid_o;
  logic                   data_out_ready_i;
  logic [DataWidth-1:0]   data_out_o;
  logic [CreditWidth-1:0] data_out_credits_o;
  logic                   data_out_credit_only_o;
  logic                   credits_rcvd_valid_i;
  logic [CreditWidth-1:0] credits_rcvd_i;
  logic                   rcvd_pkt_consumed_i;
  logic [CreditWidth-1:0] credits_avail_o;
  logic [CreditWidth-1:0] credits_pending_o;
  logic                   credit_err_o;

  modport slave (
    input  data_in_valid_i, data_in_i, data_out_ready_i,
           credits_rcvd_valid_i, credits_rcvd_i, rcvd_pkt_consumed_i,
    output data_in_ready_o, data_out_valid_o, data_out_o, data_out_credits_o,
           data_out_credit_only_o, credits_avail_o, credits_pending_o, credit_err_o
  );

  modport master (
    output data_in_valid_i, data_in_i, data_out_ready_i,
           credits_rcvd_valid_i, credits_rcvd_i, rcvd_pkt_consumed_i,
    input  data_in_ready_o, data_out_valid_o, data_out_o, data_out_credits_o,
           data_out_credit_only_o, credits_avail_o, credits_pending_o, credit_err_o
  );

endinterface

// File: rtl/serial_link_credit_ctrl.sv
// Credit-based flow control between the link-layer packetizer and PHY TX.
// Outgoing packets are gated on the credits that remain for the peer's receive
// FIFO. Packets that the local consumer pops are counted as pending credits and
// are returned to the peer. They ride on data packets, or go in a credit-only
// packet once ForceSendThresh of them have built up.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : serial_link_credit_ctrl_if.slave (packet in/out, credit return,
//             consume pulse, counter and error status)
//   state_o : current launch FSM state (debug)
module serial_link_credit_ctrl #(
  parameter int NumCredits      = serial_link_pkg::NumCredits,
  parameter int ForceSendThresh = NumCredits / 2,
  parameter int DataWidth       = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  serial_link_credit_ctrl_if.slave      bus,
  output serial_link_pkg::credit_state_e state_o
);

  localparam int CW = $clog2(NumCredits) + 1;
  // One extra bit so that an overflowing sum is visible before saturation.
  localparam int SW = CW + 1;

  serial_link_pkg::credit_state_e state_q, state_d;

  logic [CW-1:0]        avail_q, avail_d;
  logic [CW-1:0]        pending_q, pending_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] data_q;
  logic [CW-1:0]        cred_q;
  logic                 co_q;

  logic          can_launch;
  logic          data_launch;
  logic          credit_launch;
  logic          launch;
  logic [SW-1:0] avail_sum;
  logic [SW-1:0] pending_sum;

  // Launch decision and next state.
  always_comb begin
    can_launch    = 1'b0;
    data_launch   = 1'b0;
    credit_launch = 1'b0;
    launch        = 1'b0;
    state_d       = state_q;

    // A packet that is held in Busy frees the output register only on its
    // handshake. The register can then be reloaded in the same cycle.
    can_launch = (state_q == serial_link_pkg::Idle) || bus.data_out_ready_i;

    // Data needs two credits. The last credit is kept back so that a
    // credit-only packet can always go out, and the two ends cannot deadlock
    // while each waits for the other's credits.
    data_launch   = can_launch && bus.data_in_valid_i && (avail_q >= CW'(2));
    credit_launch = can_launch && !data_launch &&
                    (pending_q >= CW'(ForceSendThresh)) && (avail_q >= CW'(1));
    launch        = data_launch || credit_launch;

    if (launch) begin
      state_d = serial_link_pkg::Busy;
    end else if ((state_q == serial_link_pkg::Busy) && bus.data_out_ready_i) begin
      state_d = serial_link_pkg::Idle;
    end
  end

  // Counter arithmetic. The credit is spent at launch, not at the handshake.
  // A launch needs avail >= 1, so the subtraction cannot underflow.
  always_comb begin
    avail_sum   = '0;
    pending_sum = '0;
    avail_d     = avail_q;
    pending_d   = pending_q;
    err_d       = err_q;

    avail_sum = {1'b0, avail_q} - SW'(launch) +
                (bus.credits_rcvd_valid_i ? {1'b0, bus.credits_rcvd_i} : SW'(0));
    pending_sum = (launch ? SW'(0) : {1'b0, pending_q}) + SW'(bus.rcvd_pkt_consumed_i);

    if (avail_sum > SW'(NumCredits)) begin
      avail_d = CW'(NumCredits);
      err_d   = 1'b1;
    end else begin
      avail_d = avail_sum[CW-1:0];
    end

    if (pending_sum > SW'(NumCredits)) begin
      pending_d = CW'(NumCredits);
      err_d     = 1'b1;
    end else begin
      pending_d = pending_sum[CW-1:0];
    end
  end

  // State, counters and the output register. A reset drops a held packet at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= serial_link_pkg::Idle;
      avail_q   <= CW'(NumCredits);
      pending_q <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      cred_q    <= '0;
      co_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      avail_q   <= avail_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      // The output register changes only on a launch. A packet that is
      // waiting for ready therefore stays stable.
      if (launch) begin
        data_q <= data_launch ? bus.data_in_i : '0;
        cred_q <= pending_q;
        co_q   <= credit_launch;
      end
    end
  end

  assign bus.data_in_ready_o        = data_launch;
  assign bus.data_out_valid_o       = (state_q == serial_link_pkg::Busy);
  assign bus.data_out_o             = data_q;
  assign bus.data_out_credits_o     = cred_q;
  assign bus.data_out_credit_only_o = co_q;
  assign bus.credits_avail_o        = avail_q;
  assign bus.credits_pending_o      = pending_q;
  assign bus.credit_err_o           = err_q;
  assign state_o                    = state_q;

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
module tb_serial_link_credit_ctrl;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam int NC = 8;
  localparam int TH = 4;
  localparam int PW = 1 + CW + DW;   // {credit_only, credits, payload}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_link_credit_ctrl_if #(.DataWidth(DW), .CreditWidth(CW)) bus ();
  serial_link_pkg::credit_state_e dut_state;

  serial_link_credit_ctrl #(.NumCredits(NC), .ForceSendThresh(TH), .DataWidth(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (dut_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic dv, input logic [DW-1:0] din, input logic ordy,
                       input logic crv, input logic [CW-1:0] crn, input logic cons);
    bus.data_in_valid_i      = dv;
    bus.data_in_i            = din;
    bus.data_out_ready_i     = ordy;
    bus.credits_rcvd_valid_i = crv;
    bus.credits_rcvd_i       = crn;
    bus.rcvd_pkt_consumed_i  = cons;
  endtask

  // Reset while idle, then release on a falling edge. Returns #1 after a rising edge.
  task automatic do_reset();
    drive(0, '0, 0, 0, '0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".state"},   PW'(dut_state),                  PW'(serial_link_pkg::Idle));
    check({tag, ".valid"},   PW'(bus.data_out_valid_o),       PW'(0));
    check({tag, ".data"},    PW'(bus.data_out_o),             PW'(0));
    check({tag, ".credits"}, PW'(bus.data_out_credits_o),     PW'(0));
    check({tag, ".conly"},   PW'(bus.data_out_credit_only_o), PW'(0));
    check({tag, ".avail"},   PW'(bus.credits_avail_o),        PW'(NC));
    check({tag, ".pending"}, PW'(bus.credits_pending_o),      PW'(0));
    check({tag, ".err"},     PW'(bus.credit_err_o),           PW'(0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          dv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          crv;
    logic [CW-1:0] crn;
    logic          cons;
    logic          e_rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cred;
    logic          e_co;
    logic [CW-1:0] e_avail;
    logic [CW-1:0] e_pend;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];
  int   vec_no = 0;

  task automatic add(input logic dv, input logic [DW-1:0] din, input logic ordy,
                     input logic crv, input int crn, input logic cons,
                     input logic rdy, input logic valid, input logic [DW-1:0] data,
                     input int cred, input logic co, input int avail, input int pend,
                     input logic err);
    vec_t v;
    v.dv = dv; v.din = din; v.ordy = ordy; v.crv = crv; v.crn = CW'(crn); v.cons = cons;
    v.e_rdy = rdy; v.e_valid = valid; v.e_data = data; v.e_cred = CW'(cred); v.e_co = co;
    v.e_avail = CW'(avail); v.e_pend = CW'(pend); v.e_err = err;
    vecs.push_back(v);
  endtask

  // Each vector holds for one clock. The ready is checked before the edge and
  // the registered outputs are checked after it. Entry is at #1 after a rising edge.
  task automatic run_vecs();
    vec_t  v;
    string t;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      vec_no++;
      t = $sformatf("v%0d", vec_no);
      drive(v.dv, v.din, v.ordy, v.crv, v.crn, v.cons);
      @(negedge clk);
      check({t, ".in_ready"}, PW'(bus.data_in_ready_o), PW'(v.e_rdy));
      @(posedge clk);
      #1;
      check({t, ".valid"},   PW'(bus.data_out_valid_o),       PW'(v.e_valid));
      check({t, ".data"},    PW'(bus.data_out_o),             PW'(v.e_data));
      check({t, ".credits"}, PW'(bus.data_out_credits_o),     PW'(v.e_cred));
      check({t, ".conly"},   PW'(bus.data_out_credit_only_o), PW'(v.e_co));
      check({t, ".avail"},   PW'(bus.credits_avail_o),        PW'(v.e_avail));
      check({t, ".pending"}, PW'(bus.credits_pending_o),      PW'(v.e_pend));
      check({t, ".err"},     PW'(bus.credit_err_o),           PW'(v.e_err));
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the packet the PHY is expected to see: it is pushed at launch
  // and popped at the handshake.
  logic [PW-1:0] exp_q[$];
  int  m_avail;
  int  m_pend;
  bit  m_err;

  task automatic run_random(input int cycles);
    logic          dv, ordy, crv, cons;
    logic [DW-1:0] din;
    logic [CW-1:0] crn;
    bit            hs, may_send, send_data, send_credit;
    int            a, p;
    m_avail = NC; m_pend = 0; m_err = 0;
    exp_q.delete();
    for (int c = 0; c < cycles; c++) begin
      dv   = ($urandom_range(0, 99) < 75);
      din  = {$urandom, $urandom};
      ordy = ($urandom_range(0, 99) < 65);
      crv  = ($urandom_range(0, 99) < 18);
      crn  = CW'($urandom_range(1, 3));
      cons = ($urandom_range(0, 99) < 35);
      drive(dv, din, ordy, crv, crn, cons);
      @(negedge clk);
      // A new packet may start when nothing is held, or when the held packet
      // leaves in this cycle.
      hs          = (exp_q.size() != 0) && ordy;
      may_send    = (exp_q.size() == 0) || hs;
      send_data   = may_send && dv && (m_avail >= 2);
      send_credit = may_send && !send_data && (m_pend >= TH) && (m_avail >= 1);
      check($sformatf("r%0d.in_ready", c), PW'(bus.data_in_ready_o), PW'(send_data));
      check($sformatf("r%0d.valid", c), PW'(bus.data_out_valid_o), PW'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        check($sformatf("r%0d.packet", c),
              {bus.data_out_credit_only_o, bus.data_out_credits_o, bus.data_out_o}, exp_q[0]);
      if (hs) void'(exp_q.pop_front());
      if (send_data)   exp_q.push_back({1'b0, CW'(m_pend), din});
      if (send_credit) exp_q.push_back({1'b1, CW'(m_pend), DW'(0)});
      a = m_avail - ((send_data || send_credit) ? 1 : 0) + (crv ? int'(crn) : 0);
      p = ((send_data || send_credit) ? 0 : m_pend) + (cons ? 1 : 0);
      if (a > NC) begin a = NC; m_err = 1; end
      if (p > NC) begin p = NC; m_err = 1; end
      m_avail = a;
      m_pend  = p;
      @(posedge clk);
      #1;
      check($sformatf("r%0d.avail", c),   PW'(bus.credits_avail_o),   PW'(m_avail));
      check($sformatf("r%0d.pending", c), PW'(bus.credits_pending_o), PW'(m_pend));
      check($sformatf("r%0d.err", c),     PW'(bus.credit_err_o),      PW'(m_err));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(0, '0, 0, 0, '0, 0);
    #23;
    check_reset_state("reset_asserted");
    do_reset();
    check_reset_state("after_reset");

    // Seven back-to-back data packets, avail 8 -> 1. The eighth stalls.
    for (int k = 1; k <= 7; k++)
      add(1, DW'(100 + k), 1, 0, 0, 0,  1, 1, DW'(100 + k), 0, 0, 8 - k, 0, 0);
    add(1, DW'(108), 1, 0, 0, 0,  0, 0, DW'(107), 0, 0, 1, 0, 0);
    // Four consumes force a credit-only packet that uses the last credit.
    for (int p = 1; p <= 4; p++)
      add(1, DW'(108), 1, 0, 0, 1,  0, 0, DW'(107), 0, 0, 1, p, 0);
    add(1, DW'(108), 1, 0, 0, 0,  0, 1, DW'(0), 4, 1, 0, 0, 0);
    add(1, DW'(108), 1, 0, 0, 0,  0, 0, DW'(0), 4, 1, 0, 0, 0);
    // Three credits return. The stalled packet goes out on the next cycle.
    add(1, DW'(108), 1, 1, 3, 0,  0, 0, DW'(0), 4, 1, 3, 0, 0);
    add(1, DW'(108), 1, 0, 0, 0,  1, 1, DW'(108), 0, 0, 2, 0, 0);
    // Build pending=2, then launch and hold with ready low for 5 cycles.
    add(0, DW'(0), 1, 0, 0, 1,  0, 0, DW'(108), 0, 0, 2, 1, 0);
    add(0, DW'(0), 1, 0, 0, 1,  0, 0, DW'(108), 0, 0, 2, 2, 0);
    add(1, DW'('hAA), 0, 0, 0, 0,  1, 1, DW'('hAA), 2, 0, 1, 0, 0);
    for (int p = 1; p <= 3; p++)
      add(0, DW'(0), 0, 0, 0, 1,  0, 1, DW'('hAA), 2, 0, 1, p, 0);
    for (int k = 0; k < 2; k++)
      add(0, DW'(0), 0, 0, 0, 0,  0, 1, DW'('hAA), 2, 0, 1, 3, 0);
    add(0, DW'(0), 1, 0, 0, 0,  0, 0, DW'('hAA), 2, 0, 1, 3, 0);
    // Consume in the same cycle as a data launch with pending=5.
    add(0, DW'(0), 1, 1, 3, 0,  0, 0, DW'('hAA), 2, 0, 4, 3, 0);
    add(1, DW'('hBB), 0, 0, 0, 0,  1, 1, DW'('hBB), 3, 0, 3, 0, 0);
    for (int p = 1; p <= 5; p++)
      add(0, DW'(0), 0, 0, 0, 1,  0, 1, DW'('hBB), 3, 0, 3, p, 0);
    add(1, DW'('hCC), 1, 0, 0, 1,  1, 1, DW'('hCC), 5, 0, 2, 1, 0);
    // Refill to 8, then one more return overflows. The error is sticky.
    add(0, DW'(0), 1, 1, 6, 0,  0, 0, DW'('hCC), 5, 0, 8, 1, 0);
    add(0, DW'(0), 1, 1, 2, 0,  0, 0, DW'('hCC), 5, 0, 8, 1, 1);
    add(0, DW'(0), 1, 0, 0, 0,  0, 0, DW'('hCC), 5, 0, 8, 1, 1);
    add(1, DW'('hDD), 0, 0, 0, 0,  1, 1, DW'('hDD), 1, 0, 7, 0, 1);
    run_vecs();

    // Reset in the middle of a held packet drops it at once and clears the error.
    rst_n = 1'b0;
    #2;
    check_reset_state("mid_transfer_reset");
    do_reset();

    // Pending saturates at NumCredits while a packet is held, which sets the error.
    // The eight credits then leave in a credit-only packet.
    add(1, DW'('hEE), 0, 0, 0, 0,  1, 1, DW'('hEE), 0, 0, 7, 0, 0);
    for (int p = 1; p <= 8; p++)
      add(0, DW'(0), 0, 0, 0, 1,  0, 1, DW'('hEE), 0, 0, 7, p, 0);
    add(0, DW'(0), 0, 0, 0, 1,  0, 1, DW'('hEE), 0, 0, 7, 8, 1);
    add(0, DW'(0), 1, 0, 0, 0,  0, 1, DW'(0), 8, 1, 6, 0, 1);
    add(0, DW'(0), 1, 0, 0, 0,  0, 0, DW'(0), 8, 1, 6, 0, 1);
    run_vecs();

    // Random traffic against the reference model.
    do_reset();
    run_random(600);

    drive(0, '0, 0, 0, '0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
